fifo_dual_port_flags: RTL and testbench
=======================================

# fifo_dual_port_flags

Parametrised synchronous FIFO, successor to the single-control-line FIFO. Separate write and read enables allow a push and a pop in the same cycle. The block adds a full 2^AddressDepth capacity, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between a producer and a consumer in the same clock domain.

## Interface
- AddressDepth, 4: pointer width; capacity = 2^AddressDepth entries (16).
- DataWide, 8: data width in bits.
- AlmostFullLevel, 12: Almost_Full asserts when Count >= this value; legal range 1..2^AddressDepth.
- AlmostEmptyLevel, 2: Almost_Empty asserts when Count <= this value; legal range 0..2^AddressDepth-1.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- CS  in  1  chip enable; 0 = no push, pop or flush, all state holds.
- Flush  in  1  synchronous empty request (qualified by CS).
- Wr_En  in  1  push Data_In this cycle.
- Rd_En  in  1  pop head entry to Data_Out this cycle.
- Clr_Err  in  1  clear sticky Overflow/Underflow (qualified by CS).
- Data_In  in  DataWide  write data.
- Data_Out  out  DataWide  registered read data.
- Count  out  AddressDepth+1  current occupancy, 0..2^AddressDepth.
- Full  out  1  Count == 2^AddressDepth.
- Empty  out  1  Count == 0.
- Almost_Full  out  1  Count >= AlmostFullLevel.
- Almost_Empty  out  1  Count <= AlmostEmptyLevel.
- Overflow  out  1  sticky: a push was dropped.
- Underflow  out  1  sticky: a pop was refused.

## Operation
- Storage: 2^AddressDepth x DataWide array. Write and read pointers are AddressDepth bits wide and wrap modulo 2^AddressDepth. Count is a separate register.
- Full, Empty, Almost_Full and Almost_Empty are decoded from the registered Count. They carry no combinational path from the inputs.
- Per-edge decision when CS=1, evaluated on the state before the edge. Priority:
  - Flush=1: pointers and Count go to 0. Wr_En and Rd_En are ignored. Data_Out and the error flags hold. Clr_Err still applies.
  - Push accepted when Wr_En=1 and (not Full, or pop accepted in the same cycle).
  - Pop accepted when Rd_En=1 and not Empty.
  - Push only: mem[wp] <= Data_In, wp+1, Count+1.
  - Pop only: Data_Out <= mem[rp], rp+1, Count-1.
  - Both accepted: both actions happen and Count is unchanged.
  - Both on Full: the pop frees the slot and the push is accepted. No Overflow.
  - Wr_En=1 and Rd_En=1 on Empty: the pop is refused and Underflow is set. The push is accepted and Count becomes 1. There is no write-to-read bypass.
  - Wr_En=1 on Full without Rd_En: the push is dropped, Overflow <= 1, memory is untouched.
  - Rd_En=1 on Empty: the pop is refused, Underflow <= 1, Data_Out holds.
- Clr_Err=1 clears both sticky flags. If a new error occurs in the same cycle, that flag is set instead (set wins).
- Data_Out changes only on an accepted pop. Otherwise it holds its last value.
- CS=0: everything holds and no error flags are set.

## Timing
- Reset (rst=0, asynchronous, immediate): pointers=0, Count=0, Data_Out=0, Full=0, Empty=1, Almost_Full=0, Almost_Empty=1, Overflow=0, Underflow=0. Memory contents are not reset.
- Reset mid-operation discards all stored data. After reset releases, the first rising edge with rst=1 behaves normally.
- Read latency is 1 cycle: the head appears on Data_Out after the edge that accepts the pop.
- Write-to-readable latency is 1 cycle: Empty drops after the edge that accepts the first push, so a pop in the next cycle succeeds.
- All status outputs update on the same edge as Count.
- Capacity is exactly 2^AddressDepth. With the defaults, the 16th accepted push sets Full.

## Test plan
- Reset then idle: rst=0 for 20 ns -> Empty=1, Almost_Empty=1, Count=0, Data_Out=00, error flags 0. With CS=0, Wr_En=1 and Data_In=AA for 2 cycles -> Count stays 0.
- Fill: push 00..0F, one per cycle -> Count steps 1..16. Almost_Full rises on the edge where Count reaches 12, Full on the 16th push. A 17th push of 10 -> dropped, Overflow=1, Count=16.
- Drain with wrap: pop 16 times -> Data_Out 00..0F in order, Empty=1 after the 16th pop. A further pop -> Underflow=1, Data_Out stays 0F. Clr_Err -> both flags 0.
- Simultaneous push/pop: starting from Count=16, Wr_En=Rd_En=1 for 4 cycles with Data_In 20..23 -> Data_Out 00..03, Count stays 16, Overflow stays 0.
- Empty corner: with Count=0, Wr_En=Rd_En=1 and Data_In=55 -> Count=1, Underflow=1, Data_Out unchanged. The next pop -> Data_Out=55.
- Flush and async reset: after 5 pushes, Flush=1 for one cycle -> Count=0, Empty=1, Data_Out held. After 3 more pushes, drop rst mid-cycle -> all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_dual_port_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_dual_port_flags                                       |
// | Description : Single-clock FIFO with independent push/pop enables,       |
// |               occupancy count, almost-full/almost-empty thresholds,      |
// |               sticky overflow/underflow flags and synchronous flush.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_dual_port_flags #(
  parameter int AddressDepth     = 4,
  parameter int DataWide         = 8,
  parameter int AlmostFullLevel  = 12,
  parameter int AlmostEmptyLevel = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CS,
  input  logic                  Flush,
  input  logic                  Wr_En,
  input  logic                  Rd_En,
  input  logic                  Clr_Err,
  input  logic [DataWide-1:0]   Data_In,
  output logic [DataWide-1:0]   Data_Out,
  output logic [AddressDepth:0] Count,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int                     c_depth     = 1 << AddressDepth;
  localparam logic [AddressDepth:0]  c_depth_cnt = (AddressDepth+1)'(c_depth);
  localparam logic [AddressDepth:0]  c_cnt_one   = (AddressDepth+1)'(1);
  localparam logic [AddressDepth-1:0] c_ptr_one  = AddressDepth'(1);
  localparam logic [AddressDepth:0]  c_af_lvl    = (AddressDepth+1)'(AlmostFullLevel);
  localparam logic [AddressDepth:0]  c_ae_lvl    = (AddressDepth+1)'(AlmostEmptyLevel);

  logic [DataWide-1:0]     mem_q [c_depth];
  logic [AddressDepth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddressDepth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddressDepth:0]   count_q, count_d;
  logic [DataWide-1:0]     data_out_q, data_out_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;

  logic full, empty;
  logic push_req, pop_req;
  logic push_acc, pop_acc;
  logic flush_acc;

  // Status flags come straight from the registered count only.
  always_comb begin
    full  = (count_q == c_depth_cnt);
    empty = (count_q == '0);
  end

  // Accept/refuse decisions and next-state for pointers, count, data and flags.
  always_comb begin
    flush_acc   = CS & Flush;
    push_req    = CS & ~Flush & Wr_En;
    pop_req     = CS & ~Flush & Rd_En;
    // A pop on a full FIFO frees the slot that a simultaneous push needs.
    pop_acc     = pop_req & ~empty;
    push_acc    = push_req & (~full | pop_acc);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush_acc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      if (pop_acc) begin
        rd_ptr_d   = rd_ptr_q + c_ptr_one;
        data_out_d = mem_q[rd_ptr_q];
      end
      if (push_acc && !pop_acc) begin
        count_d = count_q + c_cnt_one;
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - c_cnt_one;
      end
    end

    // Clear first so that an error in the same cycle re-sets its flag.
    if (CS && Clr_Err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push_req && !push_acc) begin
      overflow_d = 1'b1;
    end
    if (pop_req && empty) begin
      underflow_d = 1'b1;
    end
  end

  // Control state register; reset discards all stored entries at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= Data_In;
    end
  end

  assign Data_Out     = data_out_q;
  assign Count        = count_q;
  assign Full         = full;
  assign Empty        = empty;
  assign Almost_Full  = (count_q >= c_af_lvl);
  assign Almost_Empty = (count_q <= c_ae_lvl);
  assign Overflow     = overflow_q;
  assign Underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_dual_port_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_dual_port_flags                                    |
// | Description : Scoreboard bench with a queue-based reference model for    |
// |               fifo_dual_port_flags (directed scenarios + random traffic).|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_dual_port_flags;

  localparam int c_cap = 16;
  localparam int c_af  = 12;
  localparam int c_ae  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       CS, Flush, Wr_En, Rd_En, Clr_Err;
  logic [7:0] Data_In;
  logic [7:0] Data_Out;
  logic [4:0] Count;
  logic       Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dout;
    int cnt;
    int ovf;
    int unf;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the FIFO contents as a plain queue.
  logic [7:0] m_q[$];
  int         m_dout = 0;
  int         m_ovf  = 0;
  int         m_unf  = 0;

  fifo_dual_port_flags #(
    .AddressDepth(4), .DataWide(8), .AlmostFullLevel(c_af), .AlmostEmptyLevel(c_ae)
  ) dut (
    .clk(clk), .rst(rst), .CS(CS), .Flush(Flush), .Wr_En(Wr_En), .Rd_En(Rd_En),
    .Clr_Err(Clr_Err), .Data_In(Data_In), .Data_Out(Data_Out), .Count(Count),
    .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("data_out", int'(Data_Out), e.dout);
    chk("count", int'(Count), e.cnt);
    chk("full", int'(Full), int'(e.cnt == c_cap));
    chk("empty", int'(Empty), int'(e.cnt == 0));
    chk("almost_full", int'(Almost_Full), int'(e.cnt >= c_af));
    chk("almost_empty", int'(Almost_Empty), int'(e.cnt <= c_ae));
    chk("overflow", int'(Overflow), e.ovf);
    chk("underflow", int'(Underflow), e.unf);
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.dout = m_dout;
    e.cnt  = m_q.size();
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    return e;
  endfunction

  // Apply one cycle of stimulus, advance the model, queue the expectation.
  task automatic cycle(input bit cs, input bit fl, input bit we, input bit re,
                       input bit clr, input logic [7:0] din);
    bit pop_err, push_err;
    @(negedge clk);
    CS = cs; Flush = fl; Wr_En = we; Rd_En = re; Clr_Err = clr; Data_In = din;
    pop_err  = 1'b0;
    push_err = 1'b0;
    if (cs) begin
      if (fl) begin
        m_q.delete();
      end else begin
        if (re) begin
          if (m_q.size() == 0) pop_err = 1'b1;
          else m_dout = int'(m_q.pop_front());
        end
        if (we) begin
          if (m_q.size() >= c_cap) push_err = 1'b1;
          else m_q.push_back(din);
        end
      end
      if (clr) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (push_err) m_ovf = 1;
      if (pop_err)  m_unf = 1;
    end
    exp_q.push_back(snapshot());
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  // Monitor: one result per clock edge, compared against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) chk_all(exp_q.pop_front());
    end
  end

  initial begin
    int wbias, rbias;
    rst = 1'b0;
    CS = 0; Flush = 0; Wr_En = 0; Rd_En = 0; Clr_Err = 0; Data_In = 8'h00;
    model_reset();
    #18;
    chk_all(snapshot());
    #2;
    rst = 1'b1;

    // Chip disabled: a write attempt must not change anything.
    cycle(0, 0, 1, 0, 0, 8'hAA);
    cycle(0, 0, 1, 0, 0, 8'hAA);

    // Fill to capacity, then one push too many.
    for (int i = 0; i < 16; i++) cycle(1, 0, 1, 0, 0, 8'(i));
    cycle(1, 0, 1, 0, 0, 8'h10);

    // Drain across the pointer wrap, then one pop too many, then clear errors.
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, 0, 8'h00);
    cycle(1, 0, 0, 1, 0, 8'h00);
    cycle(1, 0, 0, 0, 1, 8'h00);

    // Refill, then simultaneous push/pop while full.
    for (int i = 0; i < 16; i++) cycle(1, 0, 1, 0, 0, 8'(i));
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1, 0, 8'(8'h20 + i));

    // Flush to empty, then push+pop on empty.
    cycle(1, 1, 0, 0, 0, 8'h00);
    cycle(1, 0, 1, 1, 0, 8'h55);
    cycle(1, 0, 0, 1, 0, 8'h00);
    cycle(1, 0, 0, 0, 1, 8'h00);

    // Flush with clear in the same cycle, after some pushes.
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0, 8'(8'h60 + i));
    cycle(1, 1, 1, 1, 1, 8'hEE);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 8'(8'h70 + i));
    cycle(1, 0, 0, 1, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h00);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk_all(snapshot());
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with phases biased toward filling or draining.
    for (int p = 0; p < 8; p++) begin
      wbias = (p % 2 == 0) ? 80 : 25;
      rbias = (p % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 50; i++) begin
        cycle(($urandom % 10) != 0, ($urandom % 60) == 0,
              ($urandom % 100) < wbias, ($urandom % 100) < rbias,
              ($urandom % 12) == 0, 8'($urandom));
      end
    end
    cycle(0, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
